en_data_arbiter: RTL and testbench

Round-robin arbiter sharing one enable/data output pair (`en`, `a`) among N requesters. Each grant opens a fixed-length enable window; the winner's data is captured at window start and held stable for the whole window. `en` therefore rises once per grant, with `a` known at every `en` rise. It sits in front of the `en`/`a` consumer and its `$rose(en) |-> !$isunknown(a)` property check, and is the sole driver of those signals.

---
 rtl/en_arb_pkg.sv | 10 +
 rtl/rr_pick.sv | 33 +++
 rtl/en_data_arbiter.sv | 120 ++++++++++++
 tb/tb_en_data_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/en_arb_pkg.sv
// Shared types for the en/a round-robin arbiter family.
package en_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first asserted req at or after ptr, scanning upward modulo N.
module rr_pick
  import en_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [PW-1:0] win_idx
);

  always_comb begin
    logic          found;
    logic [PW:0]   idx;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 0; off < N; off++) begin
      // extra bit keeps ptr+off from overflowing before the modulo fold
      idx = {1'b0, ptr} + (PW+1)'(off);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && req[idx[PW-1:0]]) begin
        found                = 1'b1;
        win_oh[idx[PW-1:0]]  = 1'b1;
        win_idx              = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/en_data_arbiter.sv
// Round-robin arbiter driving a shared en/a pair; each grant opens a HOLD-cycle
// window with the winner's data frozen on a, followed by a one-cycle gap.
//
// state | meaning
// IDLE  | no window open; arbitrate on any req
// GRANT | en high, winner data held on a
// GAP   | single low cycle so every grant yields a fresh en rise
module en_data_arbiter
  import en_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 1,
  parameter int HOLD = 4
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   grant,
  output logic           en,
  output logic [W-1:0]   a,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(HOLD + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_idx;
  logic [N-1:0]  win_oh;
  logic [N-1:0]  grant_q, grant_d;
  logic [W-1:0]  a_q, a_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic [W-1:0]  lane [N];
  logic          start, hold_done, owner_req;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane[i] = data_in[i*W +: W];
  end

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  assign start     = (state_q == IDLE) && (|req);
  assign hold_done = (cnt_q == CW'(HOLD - 1));
  assign owner_req = |(req & grant_q);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      a_q     <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GRANT;
          cnt_d   = '0;
          ptr_d   = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
        end
      end
      GRANT: begin
        if (hold_done || !owner_req) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // a only samples data_in on the capture edge; it is frozen for the rest of the window
  always_comb begin
    grant_d = '0;
    a_d     = '0;
    en_d    = (state_d == GRANT);
    busy_d  = (state_d != IDLE);
    if (start) begin
      grant_d = win_oh;
      a_d     = lane[win_idx];
    end else if (state_d == GRANT) begin
      grant_d = grant_q;
      a_d     = a_q;
    end
  end

  assign grant = grant_q;
  assign en    = en_q;
  assign a     = a_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_en_data_arbiter.sv
// Randomized and directed bench for en_data_arbiter with a window-level reference model and grant scoreboard.
module tb_en_data_arbiter;

  localparam int N    = 4;
  localparam int W    = 1;
  localparam int HOLD = 4;

  logic           clock   = 1'b0;
  logic           rst_n   = 1'b0;
  logic [N-1:0]   req     = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   grant;
  logic           en;
  logic [W-1:0]   a;
  logic           busy;

  int checks   = 0;
  int failures = 0;
  int rises    = 0;
  int r0;

  typedef struct packed {
    logic [N-1:0] g;
    logic [W-1:0] d;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_pop;

  // reference model: 0 = idle, 1 = window open, 2 = gap
  int         m_phase = 0;
  int         m_win   = 0;
  int         m_left  = 0;
  int         m_ptr   = 0;
  int         m_i;
  bit         m_found;
  logic [W-1:0] m_a = '0;
  logic       prev_en = 1'b0;

  en_data_arbiter #(.N(N), .W(W), .HOLD(HOLD)) dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .req     (req),
    .data_in (data_in),
    .grant   (grant),
    .en      (en),
    .a       (a),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_en(input string name, input int max_cyc);
    int n = 0;
    while (en !== 1'b1 && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    if (en !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s timeout en=%b after %0d cycles", name, en, n);
    end
  endtask

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_ptr   = 0;
      m_win   = 0;
      m_left  = 0;
      m_a     = '0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: begin
          if (req != '0) begin
            m_found = 1'b0;
            for (int off = 0; off < N; off++) begin
              m_i = (m_ptr + off) % N;
              if (!m_found && ((req >> m_i) & N'(1)) != '0) begin
                m_found = 1'b1;
                m_win   = m_i;
              end
            end
            m_a     = W'(data_in >> (m_win * W));
            m_left  = HOLD;
            m_ptr   = (m_win + 1) % N;
            m_phase = 1;
            exp_q.push_back(exp_t'{N'(1) << m_win, m_a});
          end
        end
        1: begin
          m_left--;
          if (m_left == 0 || ((req >> m_win) & N'(1)) == '0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    if (rst_n) begin
      chk("en", 32'(en), 32'(m_phase == 1));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("grant", 32'(grant), (m_phase == 1) ? 32'(N'(1) << m_win) : 32'd0);
      chk("a", 32'(a), (m_phase == 1) ? 32'(m_a) : 32'd0);
      if (en === 1'b1 && prev_en !== 1'b1) begin
        rises++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_rise grant=%b a=%b t=%0t", grant, a, $time);
        end else begin
          e_pop = exp_q.pop_front();
          chk("sb_grant", 32'(grant), 32'(e_pop.g));
          chk("sb_a", 32'(a), 32'(e_pop.d));
        end
      end
      prev_en = en;
    end else begin
      prev_en = 1'b0;
    end
  end

  a_known_on_rise: assert property (@(posedge clock) disable iff (!rst_n) $rose(en) |-> !$isunknown(a))
    else begin
      failures++;
      $display("FAIL a_known_on_rise a=%b t=%0t", a, $time);
    end

  initial begin
    #2;
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;

    // full contention straight out of reset: 0,1,2,3,0 at a 6-cycle period
    req = '1;
    r0  = rises;
    repeat (30) begin
      data_in = (N*W)'($urandom);
      @(negedge clock);
    end
    #1;
    chk("contention_rises", 32'(rises - r0), 32'd5);
    req = '0;
    repeat (8) @(negedge clock);

    // single requester re-grants with a fresh rise each period
    req     = 4'b0100;
    data_in = 4'b0100;
    r0      = rises;
    repeat (14) @(negedge clock);
    #1;
    chk("single_rises", 32'(rises - r0), 32'd3);
    req = '0;
    repeat (8) @(negedge clock);

    // data freeze: lane 1 goes X after capture
    req     = 4'b0010;
    data_in = 4'b0010;
    wait_en("freeze_wait", 10);
    data_in[1] = 1'bx;
    repeat (3) @(negedge clock);
    chk("freeze_a_last_cycle", 32'(a), 32'd1);
    req     = '0;
    data_in = '0;
    repeat (6) @(negedge clock);

    // early release in the second window cycle
    req     = 4'b1000;
    data_in = (N*W)'($urandom);
    wait_en("early_wait", 10);
    req = 4'b1001;
    @(negedge clock);
    chk("early_en_cycle2", 32'(en), 32'd1);
    req = 4'b0001;
    @(negedge clock);
    chk("early_en_cycle3", 32'(en), 32'd0);
    chk("early_busy_gap", 32'(busy), 32'd1);
    wait_en("early_next_wait", 4);
    chk("early_next_grant", 32'(grant), 32'h1);
    req = '0;
    repeat (8) @(negedge clock);

    // async reset in the middle of a window
    req     = 4'b0100;
    data_in = 4'b0100;
    wait_en("rst_mid_wait", 10);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_en", 32'(en), 32'd0);
    chk("rst_async_grant", 32'(grant), 32'd0);
    chk("rst_async_a", 32'(a), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    req = 4'b1111;
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    wait_en("post_rst_wait", 4);
    chk("post_rst_grant", 32'(grant), 32'h1);
    req = '0;
    repeat (8) @(negedge clock);

    // random traffic
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      data_in = (N*W)'($urandom);
      @(negedge clock);
    end
    req = '0;
    repeat (10) @(negedge clock);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
